// File: rtl/bus_rr_scheduler_pkg.sv
// rtl/bus_rr_scheduler_pkg.sv - shared types, constants and helpers for the bus round-robin scheduler
package bus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ROUTE = 2'd2,
        TURN  = 2'd3
    } sched_state_t;

    localparam int          ID_W         = 8;
    localparam logic [7:0]  BROADCAST_ID = 8'hFF;
    localparam int          PKT_MAX_W    = 1024;

    // Destination ID lives in the top ID_W bits of a packet of the given width.
    function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt, input int width);
        return pkt[width-1 -: ID_W];
    endfunction

endpackage

// File: rtl/bus_rr_scheduler_if.sv
// rtl/bus_rr_scheduler_if.sv - terminal FIFO / bus signals between the scheduler and the terminals
interface bus_rr_scheduler_if #(
    parameter int pckg_sz = 32,
    parameter int drvrs   = 16
);
    localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

    logic [drvrs-1:0]         pndng;
    logic [drvrs*pckg_sz-1:0] D_pop;
    logic [drvrs-1:0]         pop;
    logic [drvrs-1:0]         push;
    logic [pckg_sz-1:0]       D_push;
    logic [IW-1:0]            gnt_id;
    logic                     busy;
    logic                     err_dest;

    modport master (
        input  pndng, D_pop,
        output pop, push, D_push, gnt_id, busy, err_dest
    );

    modport slave (
        output pndng, D_pop,
        input  pop, push, D_push, gnt_id, busy, err_dest
    );

endinterface

// File: rtl/bus_rr_scheduler_rr_pick.sv
// rtl/bus_rr_scheduler_rr_pick.sv - combinational rotate-priority encoder
module rr_pick #(
    parameter  int N  = 16,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    int idx;

    // Scan from the farthest offset back toward ptr so the closest request wins.
    always_comb begin
        gnt_idx_o = '0;
        any_o     = |req_i;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) idx = idx - N;
            if (req_i[idx]) gnt_idx_o = IW'(idx);
        end
    end

endmodule

// File: rtl/bus_rr_scheduler.sv
// rtl/bus_rr_scheduler.sv - round-robin arbiter/router moving one packet per 4 cycles over the shared bus
module bus_rr_scheduler
    import bus_sched_pkg::*;
#(
    parameter int              pckg_sz   = 32,
    parameter int              drvrs     = 16,
    parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
    input  logic              clk,
    input  logic              reset,
    bus_rr_scheduler_if.master bus
);

    localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

    sched_state_t       state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      src_q, src_d;
    logic [pckg_sz-1:0] pkt_q, pkt_d;
    logic [pckg_sz-1:0] dpush_q, dpush_d;
    logic [drvrs-1:0]   pop_q, pop_d;
    logic [drvrs-1:0]   push_q, push_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic [IW-1:0]      win_idx;
    logic               win_any;
    logic [ID_W-1:0]    dest;
    logic [drvrs-1:0]   route_mask;
    logic               route_err;

    rr_pick #(.N(drvrs)) u_pick (
        .req_i     (bus.pndng),
        .ptr_i     (ptr_q),
        .gnt_idx_o (win_idx),
        .any_o     (win_any)
    );

    assign dest = dest_of(PKT_MAX_W'(pkt_q), pckg_sz);

    // Unicast IDs below drvrs (self included), broadcast to everyone but the source, else drop.
    always_comb begin
        route_mask = '0;
        route_err  = 1'b0;
        if (int'(dest) < drvrs) begin
            route_mask = drvrs'(1) << dest;
        end else if (dest == broadcast) begin
            route_mask = ~(drvrs'(1) << src_q);
        end else begin
            route_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            pkt_q   <= '0;
            dpush_q <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            pkt_q   <= pkt_d;
            dpush_q <= dpush_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        pkt_d   = pkt_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d = GRANT;
                    src_d   = win_idx;
                    pkt_d   = bus.D_pop[int'(win_idx)*pckg_sz +: pckg_sz];
                end
            end
            GRANT: begin
                state_d = ROUTE;
                ptr_d   = (int'(src_q) == drvrs - 1) ? '0 : src_q + 1'b1;
            end
            ROUTE:   state_d = TURN;
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered: decode from the state being entered.
    always_comb begin
        pop_d   = '0;
        push_d  = '0;
        err_d   = 1'b0;
        dpush_d = dpush_q;
        busy_d  = (state_d != IDLE);
        case (state_d)
            GRANT: pop_d = drvrs'(1) << src_d;
            ROUTE: begin
                push_d  = route_mask;
                err_d   = route_err;
                dpush_d = pkt_q;
            end
            default: ;
        endcase
    end

    assign bus.pop      = pop_q;
    assign bus.push     = push_q;
    assign bus.D_push   = dpush_q;
    assign bus.gnt_id   = src_q;
    assign bus.busy     = busy_q;
    assign bus.err_dest = err_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// tb/tb_bus_rr_scheduler.sv - self-checking bench for bus_rr_scheduler
module tb_bus_rr_scheduler;

    localparam int PW = 32;
    localparam int ND = 16;
    localparam int NV = 8;

    typedef struct {
        int          src;
        logic [31:0] head;
        logic [15:0] exp_push;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    bus_rr_scheduler_if #(.pckg_sz(PW), .drvrs(ND)) bus ();

    bus_rr_scheduler #(.pckg_sz(PW), .drvrs(ND), .broadcast(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          mp    = 0;
    logic [31:0] heads [ND];
    vec_t        tbl   [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_heads();
        for (int i = 0; i < ND; i++) bus.D_pop[i*PW +: PW] = heads[i];
    endtask

    function automatic logic [7:0] rand_dest();
        case ($urandom_range(0, 3))
            0, 1:    return 8'($urandom_range(0, ND - 1));
            2:       return 8'hFF;
            default: return 8'($urandom_range(ND, 254));
        endcase
    endfunction

    task automatic rand_heads();
        for (int i = 0; i < ND; i++) heads[i] = {rand_dest(), 24'($urandom)};
    endtask

    // One 4-cycle scheduling slot, predicted from round-robin rules; entered at a negedge with the DUT idle.
    task automatic slot(input logic [ND-1:0] pn, input bit disturb);
        int          w;
        int          d;
        logic [31:0] pk;
        logic [15:0] ep;
        logic        ee;
        bus.pndng = pn;
        drive_heads();
        @(negedge clk);
        if (pn == '0) begin
            check("idle_pop", 32'(bus.pop), 32'h0);
            check("idle_busy", 32'(bus.busy), 32'h0);
            return;
        end
        w = -1;
        for (int k = 0; k < ND; k++) begin
            if (w < 0 && pn[(mp + k) % ND]) w = (mp + k) % ND;
        end
        mp = (w + 1) % ND;
        pk = heads[w];
        d  = int'(pk[31:24]);
        ee = 1'b0;
        if (d < ND)          ep = 16'(1 << d);
        else if (d == 255)   ep = 16'hFFFF & ~16'(1 << w);
        else begin ep = 16'h0; ee = 1'b1; end
        check("grant_pop", 32'(bus.pop), 32'(1 << w));
        check("grant_id", 32'(bus.gnt_id), 32'(w));
        check("grant_push", 32'(bus.push), 32'h0);
        check("grant_busy", 32'(bus.busy), 32'h1);
        if (disturb) begin
            bus.pndng = ND'($urandom);
            rand_heads();
            drive_heads();
        end
        @(negedge clk);
        check("route_push", 32'(bus.push), 32'(ep));
        check("route_err", 32'(bus.err_dest), 32'(ee));
        check("route_data", bus.D_push, pk);
        check("route_pop", 32'(bus.pop), 32'h0);
        @(negedge clk);
        check("turn_push", 32'(bus.push), 32'h0);
        check("turn_err", 32'(bus.err_dest), 32'h0);
        check("turn_hold", bus.D_push, pk);
        @(negedge clk);
        check("back_idle", 32'(bus.busy), 32'h0);
    endtask

    initial begin
        tbl[0] = '{3,  32'h0500ABCD, 16'h0020, 1'b0};
        tbl[1] = '{7,  32'hFF000001, 16'hFF7F, 1'b0};
        tbl[2] = '{9,  32'h20000000, 16'h0000, 1'b1};
        tbl[3] = '{15, 32'h0F123456, 16'h8000, 1'b0};
        tbl[4] = '{0,  32'hFFAAAAAA, 16'hFFFE, 1'b0};
        tbl[5] = '{15, 32'h00000000, 16'h0001, 1'b0};
        tbl[6] = '{4,  32'h10FFFFFF, 16'h0000, 1'b1};
        tbl[7] = '{12, 32'hFE000000, 16'h0000, 1'b1};

        // Reset held with every terminal pending
        for (int i = 0; i < ND; i++) heads[i] = 32'h0;
        drive_heads();
        bus.pndng = '1;
        repeat (3) @(negedge clk);
        check("rst_pop", 32'(bus.pop), 32'h0);
        check("rst_push", 32'(bus.push), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_gnt", 32'(bus.gnt_id), 32'h0);
        check("rst_err", 32'(bus.err_dest), 32'h0);
        check("rst_dpush", bus.D_push, 32'h0);
        reset = 1'b0;
        slot('1, 1'b0);

        // Directed vectors with hand-derived expectations; pndng drops right after the grant
        for (int v = 0; v < NV; v++) begin
            heads[tbl[v].src] = tbl[v].head;
            drive_heads();
            bus.pndng = ND'(1) << tbl[v].src;
            @(negedge clk);
            check("tbl_pop", 32'(bus.pop), 32'(1 << tbl[v].src));
            check("tbl_gnt", 32'(bus.gnt_id), 32'(tbl[v].src));
            check("tbl_push_early", 32'(bus.push), 32'h0);
            bus.pndng = '0;
            @(negedge clk);
            check("tbl_push", 32'(bus.push), 32'(tbl[v].exp_push));
            check("tbl_err", 32'(bus.err_dest), 32'(tbl[v].exp_err));
            check("tbl_data", bus.D_push, tbl[v].head);
            check("tbl_pop_off", 32'(bus.pop), 32'h0);
            @(negedge clk);
            check("tbl_turn_push", 32'(bus.push), 32'h0);
            check("tbl_turn_busy", 32'(bus.busy), 32'h1);
            @(negedge clk);
            check("tbl_idle", 32'(bus.busy), 32'h0);
            mp = (tbl[v].src + 1) % ND;
        end

        // Randomized traffic against the round-robin model
        for (int r = 0; r < 150; r++) begin
            logic [ND-1:0] pn;
            rand_heads();
            case ($urandom_range(0, 3))
                0:       pn = '0;
                1:       pn = ND'(1) << $urandom_range(0, ND - 1);
                default: pn = ND'($urandom);
            endcase
            slot(pn, 1'(($urandom_range(0, 1))));
        end

        // Reset in the middle of ROUTE after moving the pointer away from 0
        heads[5] = 32'h02000000;
        drive_heads();
        bus.pndng = ND'(1) << 5;
        @(negedge clk);
        check("mid_pop", 32'(bus.pop), 32'h0020);
        @(negedge clk);
        check("mid_push", 32'(bus.push), 32'h0004);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_push", 32'(bus.push), 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_gnt", 32'(bus.gnt_id), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        mp = 0;

        // All pending: strict rotation with wrap, self-addressed heads
        for (int i = 0; i < ND; i++) heads[i] = {8'(i), 24'(i)};
        for (int r = 0; r < 20; r++) begin
            slot('1, 1'b0);
            check("fair_order", 32'(bus.gnt_id), 32'(r % ND));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
